// File: rtl/riscv_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
// CU_ILLEGAL_TRAP_EN adds the TRAP state to cu_state_t.
package riscv_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_JALR     = 4'd11,
      S_JALWB    = 4'd12,
      S_LUI      = 4'd13
`ifdef CU_ILLEGAL_TRAP_EN
      ,
      S_TRAP     = 4'd14
`endif
   } cu_state_t;

   typedef enum logic [1:0] {
      AOP_ADD    = 2'd0,
      AOP_RTYPE  = 2'd1,
      AOP_ITYPE  = 2'd2,
      AOP_BRANCH = 2'd3
   } alu_op_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_SUB   = 4'b0001;
   localparam logic [3:0] ALU_AND   = 4'b0010;
   localparam logic [3:0] ALU_OR    = 4'b0011;
   localparam logic [3:0] ALU_XOR   = 4'b0100;
   localparam logic [3:0] ALU_SLT   = 4'b0101;
   localparam logic [3:0] ALU_SLTU  = 4'b0110;
   localparam logic [3:0] ALU_SLL   = 4'b0111;
   localparam logic [3:0] ALU_SRL   = 4'b1000;
   localparam logic [3:0] ALU_SRA   = 4'b1001;
   localparam logic [3:0] ALU_PASSB = 4'b1111;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RD1   = 2'b10;

   localparam logic [1:0] SRCB_RD2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // Successor of DECODE for a given opcode; unknown opcodes restart the fetch.
   function automatic cu_state_t decode_next(input logic [6:0] opcode);
      case (opcode)
         OP_LOAD, OP_STORE: return S_MEMADR;
         OP_R:              return S_EXECR;
         OP_I:              return S_EXECI;
         OP_BRANCH:         return S_BRANCH;
         OP_JAL:            return S_JAL;
         OP_JALR:           return S_JALR;
         OP_LUI:            return S_LUI;
         default:           return S_FETCH;
      endcase
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps op class, funct3 and funct7[5] to an ALU operation plus an illegal-combination flag.
module alu_decoder
   import riscv_pkg::*;
(
   input  alu_op_t    op_i,
   input  logic [2:0] funct3_i,
   input  logic       funct7b5_i,
   output logic [3:0] alu_ctrl_o,
   output logic       illegal_o
);

   logic [3:0] ctrl_s;
   logic       illegal_s;
   logic       is_r_s;

   assign is_r_s = (op_i == AOP_RTYPE);

   // Illegal R/I combinations fall back to add so the instruction still retires.
   always_comb begin
      ctrl_s    = ALU_ADD;
      illegal_s = 1'b0;
      case (op_i)
         AOP_BRANCH: begin
            ctrl_s    = ALU_SUB;
            illegal_s = (funct3_i == 3'b010) || (funct3_i == 3'b011);
         end
         AOP_RTYPE, AOP_ITYPE: begin
            case (funct3_i)
               3'b000: ctrl_s = (is_r_s && funct7b5_i) ? ALU_SUB : ALU_ADD;
               3'b001: ctrl_s = ALU_SLL;
               3'b010: ctrl_s = ALU_SLT;
               3'b011: ctrl_s = ALU_SLTU;
               3'b100: ctrl_s = ALU_XOR;
               3'b101: ctrl_s = funct7b5_i ? ALU_SRA : ALU_SRL;
               3'b110: ctrl_s = ALU_OR;
               3'b111: ctrl_s = ALU_AND;
               default: ctrl_s = ALU_ADD;
            endcase
            if (is_r_s) begin
               illegal_s = funct7b5_i && (funct3_i != 3'b000) && (funct3_i != 3'b101);
            end else begin
               illegal_s = funct7b5_i && (funct3_i == 3'b001);
            end
            if (illegal_s) begin
               ctrl_s = ALU_ADD;
            end else begin
               ctrl_s = ctrl_s;
            end
         end
         default: ctrl_s = ALU_ADD;
      endcase
   end

   assign alu_ctrl_o = ctrl_s;
   assign illegal_o  = illegal_s;

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM with a timed memory handshake and sticky MemFault.
// Build option CU_ILLEGAL_TRAP_EN: illegal instructions lock the FSM in TRAP until reset.
module multicycle_control_unit
   import riscv_pkg::*;
#(
   parameter int ALU_CTRL_W  = 4,
   parameter int IMM_SRC_W   = 3,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [31:0]           Instr,
   input  logic                  Zero,
   input  logic                  Lt,
   input  logic                  Ltu,
   input  logic                  MemReady,
   output logic                  MemReq,
   output logic                  MemWrite,
   output logic                  AdrSrc,
   output logic                  IRWrite,
   output logic                  PCWrite,
   output logic                  RegWrite,
   output logic [1:0]            ResultSrc,
   output logic [1:0]            ALUSrcA,
   output logic [1:0]            ALUSrcB,
   output logic [ALU_CTRL_W-1:0] ALUControl,
   output logic [IMM_SRC_W-1:0]  ImmSrc,
   output logic                  MemFault,
   output logic                  IllegalInstr
);

   localparam int               CNT_W    = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   cu_state_t        state_q, state_d;
   logic [CNT_W-1:0] wait_q, wait_d;
   logic             fault_q, fault_d;

   logic [6:0] opcode_s;
   logic [2:0] funct3_s;
   alu_op_t    aop_s;
   logic       op_known_s;
   logic [3:0] dec_ctrl_s;
   logic       dec_illegal_s;
   logic       mem_state_s, timeout_s;
   logic       mem_req_s, mem_write_s, adr_src_s, ir_write_s, pc_write_s, reg_write_s, illegal_s;
   logic [1:0] result_src_s, src_a_s, src_b_s;
   logic [3:0] alu_ctrl_s;
   logic [2:0] imm_src_s;
   logic       unused_s;

   assign opcode_s = Instr[6:0];
   assign funct3_s = Instr[14:12];
   assign unused_s = ^{Instr[31], Instr[29:15], Instr[11:7], op_known_s, dec_illegal_s, illegal_s};

   // Opcode classification for the shared ALU decoder.
   always_comb begin
      aop_s      = AOP_ADD;
      op_known_s = 1'b1;
      case (opcode_s)
         OP_R:      aop_s = AOP_RTYPE;
         OP_I:      aop_s = AOP_ITYPE;
         OP_BRANCH: aop_s = AOP_BRANCH;
         OP_LOAD, OP_STORE, OP_JAL, OP_JALR, OP_LUI: aop_s = AOP_ADD;
         default:   op_known_s = 1'b0;
      endcase
   end

   alu_decoder u_alu_dec (
      .op_i       (aop_s),
      .funct3_i   (funct3_s),
      .funct7b5_i (Instr[30]),
      .alu_ctrl_o (dec_ctrl_s),
      .illegal_o  (dec_illegal_s)
   );

   assign mem_state_s = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
   // A MemReady arriving on the last allowed cycle still counts as success.
   assign timeout_s   = mem_state_s && !MemReady && (wait_q == CNT_LAST);

   // Next state, wait counter and Moore outputs (PCWrite/IRWrite qualified where noted).
   always_comb begin
      state_d      = state_q;
      mem_req_s    = 1'b0;
      mem_write_s  = 1'b0;
      adr_src_s    = 1'b0;
      ir_write_s   = 1'b0;
      pc_write_s   = 1'b0;
      reg_write_s  = 1'b0;
      illegal_s    = 1'b0;
      result_src_s = RES_ALUOUT;
      src_a_s      = SRCA_PC;
      src_b_s      = SRCB_RD2;
      alu_ctrl_s   = ALU_ADD;
      imm_src_s    = IMM_I;
      fault_d      = fault_q | timeout_s;
      if (mem_state_s && !MemReady && !timeout_s) begin
         wait_d = wait_q + 1'b1;
      end else begin
         wait_d = '0;
      end
      case (state_q)
         S_FETCH: begin
            mem_req_s    = 1'b1;
            src_b_s      = SRCB_FOUR;
            result_src_s = RES_ALURESULT;
            ir_write_s   = MemReady;
            pc_write_s   = MemReady;
            state_d      = MemReady ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            src_a_s   = SRCA_OLDPC;
            src_b_s   = SRCB_IMM;
            imm_src_s = IMM_B;
`ifdef CU_ILLEGAL_TRAP_EN
            state_d   = (!op_known_s || dec_illegal_s) ? S_TRAP : decode_next(opcode_s);
`else
            state_d   = decode_next(opcode_s);
`endif
         end
         S_MEMADR: begin
            src_a_s   = SRCA_RD1;
            src_b_s   = SRCB_IMM;
            imm_src_s = (opcode_s == OP_STORE) ? IMM_S : IMM_I;
            state_d   = (opcode_s == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            mem_req_s = 1'b1;
            adr_src_s = 1'b1;
            if (MemReady) begin
               state_d = S_MEMWB;
            end else if (timeout_s) begin
               state_d = S_FETCH;
            end else begin
               state_d = S_MEMREAD;
            end
         end
         S_MEMWB: begin
            result_src_s = RES_DATA;
            reg_write_s  = 1'b1;
            state_d      = S_FETCH;
         end
         S_MEMWRITE: begin
            mem_req_s   = 1'b1;
            mem_write_s = 1'b1;
            adr_src_s   = 1'b1;
            if (MemReady || timeout_s) begin
               state_d = S_FETCH;
            end else begin
               state_d = S_MEMWRITE;
            end
         end
         S_EXECR, S_EXECI: begin
            src_a_s    = SRCA_RD1;
            src_b_s    = (state_q == S_EXECI) ? SRCB_IMM : SRCB_RD2;
            alu_ctrl_s = dec_ctrl_s;
            state_d    = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write_s = 1'b1;
            state_d     = S_FETCH;
         end
         S_BRANCH: begin
            src_a_s    = SRCA_RD1;
            alu_ctrl_s = ALU_SUB;
            case (funct3_s)
               3'b000:  pc_write_s = Zero;
               3'b001:  pc_write_s = !Zero;
               3'b100:  pc_write_s = Lt;
               3'b101:  pc_write_s = !Lt;
               3'b110:  pc_write_s = Ltu;
               3'b111:  pc_write_s = !Ltu;
               default: pc_write_s = 1'b0;
            endcase
            state_d = S_FETCH;
         end
         S_JAL: begin
            src_a_s    = SRCA_OLDPC;
            src_b_s    = SRCB_FOUR;
            pc_write_s = 1'b1;
            state_d    = S_ALUWB;
         end
         S_JALR: begin
            src_a_s      = SRCA_RD1;
            src_b_s      = SRCB_IMM;
            result_src_s = RES_ALURESULT;
            pc_write_s   = 1'b1;
            state_d      = S_JALWB;
         end
         S_JALWB: begin
            src_a_s      = SRCA_OLDPC;
            src_b_s      = SRCB_FOUR;
            result_src_s = RES_ALURESULT;
            reg_write_s  = 1'b1;
            state_d      = S_FETCH;
         end
         S_LUI: begin
            src_b_s    = SRCB_IMM;
            imm_src_s  = IMM_U;
            alu_ctrl_s = ALU_PASSB;
            state_d    = S_ALUWB;
         end
`ifdef CU_ILLEGAL_TRAP_EN
         S_TRAP: begin
            illegal_s = 1'b1;
            state_d   = S_TRAP;
         end
`endif
         default: state_d = S_FETCH;
      endcase
   end

   // State register, memory wait counter and sticky fault flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         wait_q  <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         fault_q <= fault_d;
      end
   end

   assign MemReq     = rst_n & mem_req_s;
   assign MemWrite   = rst_n & mem_write_s;
   assign AdrSrc     = rst_n & adr_src_s;
   assign IRWrite    = rst_n & ir_write_s;
   assign PCWrite    = rst_n & pc_write_s;
   assign RegWrite   = rst_n & reg_write_s;
   assign ResultSrc  = rst_n ? result_src_s : 2'b00;
   assign ALUSrcA    = rst_n ? src_a_s : 2'b00;
   assign ALUSrcB    = rst_n ? src_b_s : 2'b00;
   assign ALUControl = rst_n ? ALU_CTRL_W'(alu_ctrl_s) : '0;
   assign ImmSrc     = rst_n ? IMM_SRC_W'(imm_src_s) : '0;
   assign MemFault   = fault_q;
`ifdef CU_ILLEGAL_TRAP_EN
   assign IllegalInstr = rst_n & illegal_s;
`else
   assign IllegalInstr = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: per-cycle output vectors compared against a step-table model of the ISA flow.
module tb_multicycle_control_unit;

   localparam int MEM_TO = 16;

   typedef enum {P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE, P_EXECR, P_EXECI,
                 P_ALUWB, P_BRANCH, P_JAL, P_JALR, P_JALWB, P_LUI, P_TRAP} ph_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] Instr = 32'h0;
   logic        Zero = 1'b0, Lt = 1'b0, Ltu = 1'b0, MemReady = 1'b0;
   logic        MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, MemFault, IllegalInstr;
   logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
   logic [3:0]  ALUControl;
   logic [2:0]  ImmSrc;
   logic [20:0] outvec;

   int  checks = 0;
   int  failures = 0;
   bit  exp_fault = 1'b0;
   ph_t seq[$];

   always #5 clk = ~clk;

   multicycle_control_unit #(.ALU_CTRL_W(4), .IMM_SRC_W(3), .MEM_TIMEOUT(MEM_TO)) dut (
      .clk(clk), .rst_n(rst_n), .Instr(Instr), .Zero(Zero), .Lt(Lt), .Ltu(Ltu),
      .MemReady(MemReady), .MemReq(MemReq), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
      .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc),
      .MemFault(MemFault), .IllegalInstr(IllegalInstr)
   );

   assign outvec = {MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ResultSrc,
                    ALUSrcA, ALUSrcB, ALUControl, ImmSrc, MemFault, IllegalInstr};

   function automatic bit illegal_ref(input logic [31:0] ins);
      logic [2:0] f3 = ins[14:12];
      bit         b5 = ins[30];
      case (ins[6:0])
         7'b0000011, 7'b0100011, 7'b1101111, 7'b1100111, 7'b0110111: return 1'b0;
         7'b0110011: return b5 && !(f3 == 3'd0 || f3 == 3'd5);
         7'b0010011: return b5 && (f3 == 3'd1);
         7'b1100011: return (f3 == 3'd2) || (f3 == 3'd3);
         default:    return 1'b1;
      endcase
   endfunction

   // ALU operation for an R/I arithmetic instruction, by mnemonic.
   function automatic logic [3:0] alu_ref(input logic [31:0] ins);
      bit is_r = (ins[6:0] == 7'b0110011);
      if (illegal_ref(ins)) return 4'd0;
      case (ins[14:12])
         3'd0: return (is_r && ins[30]) ? 4'd1 : 4'd0;  // sub : add
         3'd1: return 4'd7;                             // sll
         3'd2: return 4'd5;                             // slt
         3'd3: return 4'd6;                             // sltu
         3'd4: return 4'd4;                             // xor
         3'd5: return ins[30] ? 4'd9 : 4'd8;            // sra : srl
         3'd6: return 4'd3;                             // or
         default: return 4'd2;                          // and
      endcase
   endfunction

   function automatic bit taken_ref(input logic [2:0] f3, input bit z, input bit lt, input bit ltu);
      case (f3)
         3'd0: return z;
         3'd1: return !z;
         3'd4: return lt;
         3'd5: return !lt;
         3'd6: return ltu;
         3'd7: return !ltu;
         default: return 1'b0;
      endcase
   endfunction

   function automatic void build_seq(input logic [31:0] ins);
      seq.delete();
      seq.push_back(P_FETCH);
      seq.push_back(P_DECODE);
`ifdef CU_ILLEGAL_TRAP_EN
      if (illegal_ref(ins)) begin
         seq.push_back(P_TRAP);
         return;
      end
`endif
      case (ins[6:0])
         7'b0000011: begin seq.push_back(P_MEMADR); seq.push_back(P_MEMREAD); seq.push_back(P_MEMWB); end
         7'b0100011: begin seq.push_back(P_MEMADR); seq.push_back(P_MEMWRITE); end
         7'b0110011: begin seq.push_back(P_EXECR); seq.push_back(P_ALUWB); end
         7'b0010011: begin seq.push_back(P_EXECI); seq.push_back(P_ALUWB); end
         7'b1100011: seq.push_back(P_BRANCH);
         7'b1101111: begin seq.push_back(P_JAL); seq.push_back(P_ALUWB); end
         7'b1100111: begin seq.push_back(P_JALR); seq.push_back(P_JALWB); end
         7'b0110111: begin seq.push_back(P_LUI); seq.push_back(P_ALUWB); end
         default: ;
      endcase
   endfunction

   function automatic logic [20:0] exp_vec(input ph_t p, input logic [31:0] ins, input bit rdy,
                                           input bit z, input bit lt, input bit ltu);
      logic mreq = 0, mw = 0, adr = 0, irw = 0, pcw = 0, rw = 0, ill = 0;
      logic [1:0] rs = 0, sa = 0, sb = 0;
      logic [3:0] ac = 0;
      logic [2:0] is = 0;
      case (p)
         P_FETCH:    begin mreq = 1; sb = 2; rs = 2; irw = rdy; pcw = rdy; end
         P_DECODE:   begin sa = 1; sb = 1; is = 3'b010; end
         P_MEMADR:   begin sa = 2; sb = 1; is = (ins[6:0] == 7'b0100011) ? 3'b001 : 3'b000; end
         P_MEMREAD:  begin mreq = 1; adr = 1; end
         P_MEMWB:    begin rs = 1; rw = 1; end
         P_MEMWRITE: begin mreq = 1; mw = 1; adr = 1; end
         P_EXECR:    begin sa = 2; ac = alu_ref(ins); end
         P_EXECI:    begin sa = 2; sb = 1; ac = alu_ref(ins); end
         P_ALUWB:    rw = 1;
         P_BRANCH:   begin sa = 2; ac = 1; pcw = taken_ref(ins[14:12], z, lt, ltu); end
         P_JAL:      begin sa = 1; sb = 2; pcw = 1; end
         P_JALR:     begin sa = 2; sb = 1; rs = 2; pcw = 1; end
         P_JALWB:    begin sa = 1; sb = 2; rs = 2; rw = 1; end
         P_LUI:      begin sb = 1; is = 3'b100; ac = 4'hF; end
         default:    ill = 1;
      endcase
      return {mreq, mw, adr, irw, pcw, rw, rs, sa, sb, ac, is, exp_fault, ill};
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      for (int t = 0; t < 50; t++) begin
         r = $urandom;
         case ($urandom_range(0, 9))
            0: r[6:0] = 7'b0000011;
            1: r[6:0] = 7'b0100011;
            2: r[6:0] = 7'b0110011;
            3: r[6:0] = 7'b0010011;
            4: r[6:0] = 7'b1100011;
            5: r[6:0] = 7'b1101111;
            6: r[6:0] = 7'b1100111;
            7: r[6:0] = 7'b0110111;
            8: r[6:0] = 7'b0110011;
            default: r[6:0] = 7'b1011011;
         endcase
`ifdef CU_ILLEGAL_TRAP_EN
         if (!illegal_ref(r)) return r;
`else
         return r;
`endif
      end
      return 32'h002081B3;
   endfunction

   // Runs one instruction from FETCH; flags<0 randomises Zero/Lt/Ltu, max_ph<0 runs every step.
   task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input int flags,
                            input int max_ph, input string tag);
      logic [20:0] exp;
      int waits;
      bit is_mem;
      build_seq(ins);
      Instr = ins;
      for (int i = 0; i < seq.size() && (max_ph < 0 || i < max_ph); i++) begin
         is_mem = (seq[i] == P_FETCH) || (seq[i] == P_MEMREAD) || (seq[i] == P_MEMWRITE);
         waits  = (seq[i] == P_FETCH) ? fw : (is_mem ? mw : 0);
         for (int w = 0; w <= waits && w < MEM_TO; w++) begin
            MemReady = is_mem ? (w == waits) : 1'($urandom_range(0, 1));
            if (flags < 0) {Zero, Lt, Ltu} = 3'($urandom);
            else {Zero, Lt, Ltu} = 3'(flags);
            #1;
            exp = exp_vec(seq[i], ins, MemReady, Zero, Lt, Ltu);
            checks++;
            if (outvec !== exp) begin
               failures++;
               $display("FAIL %s step%0d/%s wait%0d: got=%b exp=%b", tag, i, seq[i].name(), w, outvec, exp);
            end
            @(posedge clk);
            #2;
            if (w == MEM_TO - 1 && w != waits) begin
               exp_fault = 1'b1;
               return;
            end
         end
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      exp_fault = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
         Instr = $urandom;
         MemReady = 1'($urandom_range(0, 1));
         @(posedge clk);
         #2;
         checks++;
         if (outvec !== 21'd0) begin
            failures++;
            $display("FAIL reset_hold%0d: got=%b exp=%b", k, outvec, 21'd0);
         end
      end
      rst_n = 1'b1;
      exp_fault = 1'b0;
      MemReady = 1'b0;
      #1;
      checks++;
      if (outvec !== exp_vec(P_FETCH, Instr, 1'b0, 1'b0, 1'b0, 1'b0)) begin
         failures++;
         $display("FAIL reset_release: got=%b exp=%b", outvec, exp_vec(P_FETCH, Instr, 1'b0, 1'b0, 1'b0, 1'b0));
      end
   endtask

   task automatic test_add();
      run_instr(32'h002081B3, 0, 0, -1, -1, "add");
      MemReady = 1'b0;
      #1;
      checks++;
      if (outvec !== exp_vec(P_FETCH, Instr, 1'b0, 1'b0, 1'b0, 1'b0)) begin
         failures++;
         $display("FAIL add_back_to_fetch: got=%b exp=%b", outvec, exp_vec(P_FETCH, Instr, 1'b0, 1'b0, 1'b0, 1'b0));
      end
      do_reset();
   endtask

   task automatic test_load_store_wait();
      run_instr(32'h0080A283, 0, 3, -1, -1, "lw_wait3");
      run_instr(32'h0050A423, 1, 2, -1, -1, "sw_wait2");
   endtask

   task automatic test_branches();
      run_instr(32'h00209463, 0, 0, 3'b100, -1, "bne_zero1");
      run_instr(32'h0020C463, 0, 0, 3'b010, -1, "blt_lt1");
      run_instr(32'h0020E463, 0, 0, 3'b001, -1, "bltu_ltu1");
      run_instr(32'h0020F463, 0, 0, 3'b001, -1, "bgeu_ltu1");
   endtask

   task automatic test_jumps_lui();
      run_instr(32'h000100E7, 0, 0, -1, -1, "jalr");
      run_instr(32'h123452B7, 0, 0, -1, -1, "lui");
      run_instr(32'h008000EF, 0, 0, -1, -1, "jal");
   endtask

   task automatic test_illegal();
      run_instr(32'hFFFFFFFF, 0, 0, -1, -1, "illegal_op");
      for (int k = 0; k < 3; k++) begin
         MemReady = 1'b0;
         #1;
`ifdef CU_ILLEGAL_TRAP_EN
         checks++;
         if (outvec !== exp_vec(P_TRAP, Instr, 1'b0, 1'b0, 1'b0, 1'b0)) begin
            failures++;
            $display("FAIL trap_hold%0d: got=%b exp=%b", k, outvec, exp_vec(P_TRAP, Instr, 1'b0, 1'b0, 1'b0, 1'b0));
         end
`else
         checks++;
         if (outvec !== exp_vec(P_FETCH, Instr, 1'b0, 1'b0, 1'b0, 1'b0)) begin
            failures++;
            $display("FAIL illegal_refetch%0d: got=%b exp=%b", k, outvec, exp_vec(P_FETCH, Instr, 1'b0, 1'b0, 1'b0, 1'b0));
         end
`endif
         @(posedge clk);
         #2;
      end
      do_reset();
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         run_instr(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 3), -1, -1, "random");
      end
      do_reset();
   endtask

   task automatic test_timeout();
      run_instr(32'h002081B3, MEM_TO - 1, 0, -1, -1, "fetch_ready_at_limit");
      do_reset();
      run_instr(32'h002081B3, MEM_TO + 4, 0, -1, -1, "fetch_timeout");
      checks++;
      if (exp_fault !== 1'b1 || MemFault !== 1'b1) begin
         failures++;
         $display("FAIL fetch_timeout_fault: got=%b exp=1", MemFault);
      end
      run_instr(32'h002081B3, 0, 0, -1, -1, "after_fetch_timeout");
      do_reset();
      run_instr(32'h0080A283, 0, MEM_TO + 2, -1, -1, "lw_timeout");
      run_instr(32'h0050A423, 0, 1, -1, -1, "after_lw_timeout");
      do_reset();
   endtask

   task automatic test_reset_midinstr();
      run_instr(32'h0050A423, 0, 0, -1, 3, "sw_partial");
      MemReady = 1'b0;
      #1;
      checks++;
      if (MemWrite !== 1'b1) begin
         failures++;
         $display("FAIL in_memwrite: got MemWrite=%b exp=1", MemWrite);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (outvec !== 21'd0) begin
         failures++;
         $display("FAIL reset_in_memwrite: got=%b exp=%b", outvec, 21'd0);
      end
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      #1;
      checks++;
      if (outvec !== exp_vec(P_FETCH, Instr, 1'b0, 1'b0, 1'b0, 1'b0)) begin
         failures++;
         $display("FAIL after_reset_memwrite: got=%b exp=%b", outvec, exp_vec(P_FETCH, Instr, 1'b0, 1'b0, 1'b0, 1'b0));
      end
      do_reset();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_add();
      test_load_store_wait();
      test_branches();
      test_jumps_lui();
      test_illegal();
      test_random();
      test_timeout();
      test_reset_midinstr();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Parametrised successor to the single-cycle RV32I decoder: an FSM that sequences the shared-memory multicycle datapath (fetch, decode, execute, memory, writeback) over several cycles per instruction.
- Supports the full RV32I integer ALU/branch subset.
- Waits on a ready/request memory handshake, with a timeout fault.
- Sits between the instruction register, the ALU flags, the memory port and the datapath muxes/enables.

Parameters:
- ALU_CTRL_W, 4, width of ALUControl.
- IMM_SRC_W, 3, width of ImmSrc.
- MEM_TIMEOUT, 16, maximum cycles to wait for MemReady before MemFault; must be ≥1.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- Instr  in  32  current instruction register contents.
- Zero  in  1  ALU result == 0.
- Lt  in  1  signed SrcA < SrcB.
- Ltu  in  1  unsigned SrcA < SrcB.
- MemReady  in  1  memory completes the current access this cycle.
- MemReq  out  1  memory access requested.
- MemWrite  out  1  request is a store.
- AdrSrc  out  1  0 = PC, 1 = ALUOut.
- IRWrite  out  1  load the instruction register.
- PCWrite  out  1  load the PC.
- RegWrite  out  1  register file write.
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult.
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 RD1.
- ALUSrcB  out  2  00 RD2, 01 ImmExt, 10 constant 4.
- ALUControl  out  ALU_CTRL_W  ALU operation.
- ImmSrc  out  IMM_SRC_W  000 I, 001 S, 010 B, 011 J, 100 U.
- MemFault  out  1  sticky; memory timeout occurred.
- IllegalInstr  out  1  illegal opcode/funct combination (trap build only).

Behaviour:
- Reset: when rst_n == 0 at a rising edge:
  - state <= FETCH, wait counter <= 0, MemFault <= 0.
  - While rst_n is low, every enable (MemReq, MemWrite, IRWrite, PCWrite, RegWrite) is forced to 0 and all selects are 0.
  - Reset mid-instruction abandons that instruction with no further writes.
- Outputs are Moore (decoded from state), except:
  - PCWrite in BRANCH;
  - IRWrite/PCWrite in FETCH, which are qualified by MemReady.
- FETCH:
  - MemReq=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUControl=add, ResultSrc=10.
  - On MemReady: IRWrite=1, PCWrite=1, go to DECODE. Otherwise stay.
- DECODE: ALUSrcA=01, ALUSrcB=01, ImmSrc=B, add (branch target precompute). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - any other opcode -> FETCH (or TRAP if enabled)
- MEMADR: RD1 + ImmExt; ImmSrc = S for stores, I for loads. Go to MEMREAD for loads, MEMWRITE for stores.
- MEMREAD: MemReq=1, AdrSrc=1; on MemReady go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, go to FETCH.
- MEMWRITE: MemReq=1, MemWrite=1, AdrSrc=1; on MemReady go to FETCH.
- EXECR / EXECI:
  - ALUSrcA=10; ALUSrcB = 00 (EXECR) or 01 with ImmSrc=I (EXECI).
  - ALUControl from funct3 / funct7[5]: add, sub, and, or, xor, slt, sltu, sll, srl, sra.
  - sub is R-type only; srai is selected by Instr[30].
  - Go to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, go to FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00.
  - PCWrite = taken, with funct3 000 beq Zero, 001 bne !Zero, 100 blt Lt, 101 bge !Lt, 110 bltu Ltu, 111 bgeu !Ltu.
  - Go to FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1; go to ALUWB (writes PC+4).
- JALR: ALUSrcA=10, ALUSrcB=01, ImmSrc=I, add, ResultSrc=10, PCWrite=1; go to JALWB.
- JALWB: writes OldPC+4 via ALUSrcA=01, ALUSrcB=10, ResultSrc=10, RegWrite=1; go to FETCH.
- LUI: ImmSrc=U, ALUSrcB=01, ALUControl=passB; go to ALUWB.
- Memory wait counter:
  - Counts cycles spent in FETCH/MEMREAD/MEMWRITE with MemReady=0; cleared on state exit.
  - On reaching MEM_TIMEOUT: MemFault <= 1 (sticky until reset), drop MemReq, go to FETCH.
  - MemReady in the same cycle the count hits the limit takes priority as success.
- Illegal funct3/funct7 combinations in non-trap builds execute as add and retire normally.

Optional Feature:
- Macro: CU_ILLEGAL_TRAP_EN.
- Defined:
  - An illegal opcode, or an illegal funct combination detected in DECODE, goes to TRAP.
  - TRAP asserts IllegalInstr=1 and all enables 0, and holds until reset.
- Undefined:
  - No TRAP state; IllegalInstr is tied to 0.
  - An illegal opcode returns to FETCH with no writes.

Decomposition:
- Package riscv_pkg holds:
  - state enum typedef (cu_state_t);
  - opcode constants;
  - ALUControl encodings: add 0000, sub 0001, and 0010, or 0011, xor 0100, slt 0101, sltu 0110, sll 0111, srl 1000, sra 1001, passB 1111;
  - ImmSrc, ResultSrc and ALUSrc encodings.
- Sub-module alu_decoder: combinational mapping of op class, funct3 and funct7[5] to ALUControl plus an illegal flag. It is reused by the FSM states.

Test Plan:
- Reset, then add x3,x1,x2 with MemReady=1: FETCH, DECODE, EXECR, ALUWB, back to FETCH (4 cycles); ALUControl=0000 in EXECR; RegWrite=1 only in ALUWB.
- lw with MemReady held low 3 cycles in MEMREAD: state stays in MEMREAD for those 3 cycles, then MEMWB with ResultSrc=01; MemFault stays 0.
- MemReady held low for 16 cycles in FETCH (MEM_TIMEOUT=16): MemFault=1, state returns to FETCH, IRWrite never asserted.
- bne with Zero=1, then blt with Lt=1: PCWrite=0 in BRANCH for bne, then PCWrite=1 in BRANCH for blt.
- jalr then lui: PCWrite=1 in JALR and RegWrite=1 in JALWB; LUI sets ALUControl=1111, ImmSrc=100.
- Opcode 7'b1111111 with CU_ILLEGAL_TRAP_EN: IllegalInstr=1, no enables asserted. Without the macro: returns to FETCH with no writes.
- Assert rst_n=0 in MEMWRITE: next cycle state is FETCH, MemWrite=0.
